counter: RTL and testbench

// - Synchronous binary up/down counter with count enable.
// - General-purpose event/cycle counter for datapath and control logic.
// - Free-running modulo-2^WIDTH: wraps in both directions.
// - No load and no clear other than reset.
//

---
 rtl/counter.sv | 65 ++++++
 tb/tb_counter.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/counter.sv
// rtl/counter.sv - WIDTH-bit binary up/down counter with count enable
//
// Purpose:
//   Free-running modulo-2^WIDTH event/cycle counter. Counts up or down on each
//   rising clk edge while enable is high, and wraps in both directions. There
//   is no load and no clear other than reset.
//
// Parameters:
//   WIDTH   counter width in bits, 2..32 (default 8)
//
// Ports:
//   clk     in   1      clock, all state updates on the rising edge
//   reset   in   1      asynchronous, active-high; forces cnt to 0 at once
//   enable  in   1      1 = count on this edge, 0 = hold
//   upndwn  in   1      1 = increment, 0 = decrement
//   cnt     out  WIDTH  current count, straight from the register
//   tc      out  1      terminal count (only when COUNTER_TC_EN is defined)
//
// Configuration:
//   COUNTER_TC_EN  when defined, adds the tc output. Counting is identical
//                  in both builds.

module counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             upndwn,
`ifdef COUNTER_TC_EN
    output logic             tc,
`endif
    output logic [WIDTH-1:0] cnt
);

    // Plain modulo arithmetic: the carry/borrow out of the top bit is
    // dropped, which gives 2^WIDTH-1 -> 0 going up and 0 -> 2^WIDTH-1 going
    // down without any special-case logic.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (enable) begin
            if (upndwn) begin
                cnt <= cnt + WIDTH'(1);
            end else begin
                cnt <= cnt - WIDTH'(1);
            end
        end
    end

`ifdef COUNTER_TC_EN
    // tc flags that the next count in the selected direction will wrap. It
    // looks only at cnt and upndwn, so it is valid even while enable is low
    // (and reads 1 during reset when counting down, since cnt is 0 then).
    always_comb begin
        tc = 1'b0;
        if (upndwn) begin
            tc = &cnt;
        end else begin
            tc = (cnt == '0);
        end
    end
`endif

endmodule

// File: tb/tb_counter.sv
// tb/tb_counter.sv - directed table-driven bench for counter

module tb_counter;

    localparam int WIDTH = 8;

    logic             clk;
    logic             clk_run;
    logic             reset;
    logic             enable;
    logic             upndwn;
    logic [WIDTH-1:0] cnt;
`ifdef COUNTER_TC_EN
    logic             tc;
`endif

    int nvec;
    int nfail;

    typedef struct {
        logic             rst;
        logic             en;
        logic             up;
        logic [WIDTH-1:0] exp;
    } vec_t;

    vec_t vecs[$];

    counter #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .upndwn (upndwn),
`ifdef COUNTER_TC_EN
        .tc     (tc),
`endif
        .cnt    (cnt)
    );

    initial clk = 1'b0;
    always #5 if (clk_run) clk = ~clk;

    function automatic vec_t mk(logic r, logic e, logic u, int x);
        vec_t v;
        v.rst = r;
        v.en  = e;
        v.up  = u;
        v.exp = x[WIDTH-1:0];
        return v;
    endfunction

    task automatic check(input string name, input logic [WIDTH-1:0] exp);
        nvec++;
        if (cnt !== exp) begin
            nfail++;
            $display("FAIL %s: cnt=%0d expected %0d", name, cnt, exp);
        end
`ifdef COUNTER_TC_EN
        begin
            logic exp_tc;
            exp_tc = upndwn ? (exp == {WIDTH{1'b1}}) : (exp == '0);
            nvec++;
            if (tc !== exp_tc) begin
                nfail++;
                $display("FAIL %s_tc: tc=%b expected %b (cnt=%0d upndwn=%b)",
                         name, tc, exp_tc, cnt, upndwn);
            end
        end
`endif
    endtask

    task automatic step(input logic r, input logic e, input logic u);
        reset  = r;
        enable = e;
        upndwn = u;
        @(negedge clk);
    endtask

    initial begin
        nvec    = 0;
        nfail   = 0;
        clk_run = 1'b0;
        reset   = 1'b0;
        enable  = 1'b0;
        upndwn  = 1'b1;

        // Vector table: each entry is applied for one rising edge and cnt is
        // checked on the following falling edge.
        for (int i = 0; i < 5; i++) vecs.push_back(mk(0, 0, 1, 0));   // hold at 0
        vecs.push_back(mk(0, 1, 0, 255));                              // down wraps
        vecs.push_back(mk(0, 1, 0, 254));
        vecs.push_back(mk(0, 1, 0, 253));
        vecs.push_back(mk(1, 1, 1, 0));                                // reset wins
        for (int i = 1; i <= 10; i++) vecs.push_back(mk(0, 1, 1, i));  // up to 10
        vecs.push_back(mk(0, 0, 1, 10));                               // hold, upndwn ignored
        vecs.push_back(mk(0, 0, 0, 10));
        vecs.push_back(mk(0, 0, 1, 10));
        vecs.push_back(mk(0, 1, 0, 9));                                // down 2
        vecs.push_back(mk(0, 1, 0, 8));
        vecs.push_back(mk(0, 1, 1, 9));                                // direction flips same edge
        vecs.push_back(mk(0, 1, 0, 8));
        vecs.push_back(mk(0, 0, 0, 8));

        // Asynchronous reset with the clock stopped.
        #2 reset = 1'b1;
        #1 check("reset_no_clock", 0);
        clk_run = 1'b1;
        @(negedge clk);
        check("reset_held", 0);

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].en, vecs[i].up);
            check($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Full up-count through the wrap.
        step(1, 0, 1);
        check("full_up_start", 0);
        for (int i = 1; i <= 256; i++) begin
            step(0, 1, 1);
            check($sformatf("full_up_%0d", i), i[WIDTH-1:0]);
        end

        // Count to 100, then pulse reset between edges.
        for (int i = 0; i < 100; i++) step(0, 1, 1);
        check("at_100", 100);
        enable = 1'b0;
        #2 reset = 1'b1;
        #1 check("mid_reset", 0);
        #1 reset = 1'b0;
        @(negedge clk);
        step(0, 1, 1);
        check("after_mid_reset", 1);

`ifdef COUNTER_TC_EN
        // Terminal count around the top of the range.
        step(1, 0, 1);
        check("tc_reset_up", 0);
        upndwn = 1'b0;
        #1 check("tc_reset_down", 0);
        @(negedge clk);
        step(0, 1, 0);
        step(0, 1, 0);
        enable = 1'b0;
        upndwn = 1'b1;
        #1 check("tc_at_254", 254);
        @(negedge clk);
        step(0, 1, 1);
        enable = 1'b0;
        #1 check("tc_at_255_hold", 255);
        @(negedge clk);
        step(0, 1, 1);
        check("tc_wrap_0", 0);
        upndwn = 1'b0;
        #1 check("tc_down_at_0", 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
